// File: rtl/immenc.sv
// rtl/immenc.sv - RV32I immediate encoder with two-stage valid/ready pipeline
//
// Purpose: range-checks an immediate for a given kind and scatters it into
// the RV32I field positions of an instruction template.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   request handshake
//   in_base/kind/imm    template, immediate kind (0..7), immediate value
//   out_valid/out_ready result handshake
//   out_instr/out_err   encoded instruction, not-encodable flag
//   cnt_clr             synchronous clear of both status counters
//   ok_cnt/err_cnt      saturating result counters
module immenc (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_base,
  input  logic [2:0]  in_kind,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  input  logic        cnt_clr,
  output logic [15:0] ok_cnt,
  output logic [15:0] err_cnt
);

  localparam logic [2:0] K_NONE  = 3'd0;
  localparam logic [2:0] K_SHAMT = 3'd1;
  localparam logic [2:0] K_I     = 3'd2;
  localparam logic [2:0] K_S     = 3'd3;
  localparam logic [2:0] K_B     = 3'd4;
  localparam logic [2:0] K_U     = 3'd5;
  localparam logic [2:0] K_J     = 3'd6;

  logic        s1_valid_q, s1_valid_d;
  logic [31:0] s1_base_q,  s1_base_d;
  logic [2:0]  s1_kind_q,  s1_kind_d;
  logic [31:0] s1_imm_q,   s1_imm_d;
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s2_instr_q, s2_instr_d;
  logic        s2_err_q,   s2_err_d;
  logic [15:0] ok_cnt_q,   ok_cnt_d;
  logic [15:0] err_cnt_q,  err_cnt_d;

  logic        s1_adv, s2_adv;
  logic        s1_err;
  logic [31:0] s1_packed;
  logic        out_hs;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv && !rst;
  assign out_hs   = s2_valid_q && out_ready;

  // Signed range checks reduce to "all bits above the field's sign bit equal
  // the sign bit". B and J additionally require an even byte offset; since
  // the upper bound is the largest even value, the sign check plus imm[0]==0
  // gives exactly -4096..4094 and -1048576..1048574.
  always_comb begin
    s1_err = 1'b0;
    case (s1_kind_q)
      K_NONE:  s1_err = 1'b0;
      K_SHAMT: s1_err = |s1_imm_q[31:5];
      K_I,
      K_S:     s1_err = !(&s1_imm_q[31:11] || ~|s1_imm_q[31:11]);
      K_B:     s1_err = !(&s1_imm_q[31:12] || ~|s1_imm_q[31:12]) || s1_imm_q[0];
      K_U:     s1_err = |s1_imm_q[11:0];
      K_J:     s1_err = !(&s1_imm_q[31:20] || ~|s1_imm_q[31:20]) || s1_imm_q[0];
      default: s1_err = 1'b1;
    endcase
  end

  always_comb begin
    s1_packed = s1_base_q;
    if (!s1_err) begin
      case (s1_kind_q)
        K_SHAMT: s1_packed[24:20] = s1_imm_q[4:0];
        K_I:     s1_packed[31:20] = s1_imm_q[11:0];
        K_S: begin
          s1_packed[31:25] = s1_imm_q[11:5];
          s1_packed[11:7]  = s1_imm_q[4:0];
        end
        K_B: begin
          s1_packed[31]    = s1_imm_q[12];
          s1_packed[30:25] = s1_imm_q[10:5];
          s1_packed[11:8]  = s1_imm_q[4:1];
          s1_packed[7]     = s1_imm_q[11];
        end
        K_U:     s1_packed[31:12] = s1_imm_q[31:12];
        K_J: begin
          s1_packed[31]    = s1_imm_q[20];
          s1_packed[30:21] = s1_imm_q[10:1];
          s1_packed[20]    = s1_imm_q[11];
          s1_packed[19:12] = s1_imm_q[19:12];
        end
        default: s1_packed = s1_base_q;
      endcase
    end
  end

  // Stage registers only load when their stage advances, so a stalled item
  // stays bit-stable while valid.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_base_d  = s1_base_q;
    s1_kind_d  = s1_kind_q;
    s1_imm_d   = s1_imm_q;
    s2_valid_d = s2_valid_q;
    s2_instr_d = s2_instr_q;
    s2_err_d   = s2_err_q;
    ok_cnt_d   = ok_cnt_q;
    err_cnt_d  = err_cnt_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_base_d = in_base;
        s1_kind_d = in_kind;
        s1_imm_d  = in_imm;
      end
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_instr_d = s1_packed;
        s2_err_d   = s1_err;
      end
    end

    if (cnt_clr) begin
      ok_cnt_d  = 16'd0;
      err_cnt_d = 16'd0;
    end else if (out_hs) begin
      if (!s2_err_q && ok_cnt_q != 16'hFFFF)
        ok_cnt_d = ok_cnt_q + 16'd1;
      if (s2_err_q && err_cnt_q != 16'hFFFF)
        err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_base_q  <= 32'd0;
      s1_kind_q  <= 3'd0;
      s1_imm_q   <= 32'd0;
      s2_valid_q <= 1'b0;
      s2_instr_q <= 32'd0;
      s2_err_q   <= 1'b0;
      ok_cnt_q   <= 16'd0;
      err_cnt_q  <= 16'd0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_base_q  <= s1_base_d;
      s1_kind_q  <= s1_kind_d;
      s1_imm_q   <= s1_imm_d;
      s2_valid_q <= s2_valid_d;
      s2_instr_q <= s2_instr_d;
      s2_err_q   <= s2_err_d;
      ok_cnt_q   <= ok_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_instr = s2_instr_q;
  assign out_err   = s2_err_q;
  assign ok_cnt    = ok_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_immenc.sv
// tb/tb_immenc.sv - scoreboard testbench for immenc
module tb_immenc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_base = 32'd0;
  logic [2:0]  in_kind = 3'd0;
  logic [31:0] in_imm = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        out_err;
  logic        cnt_clr = 1'b0;
  logic [15:0] ok_cnt;
  logic [15:0] err_cnt;

  int n_tests = 0;
  int n_fail = 0;
  int n_acc = 0;
  logic [32:0] sb[$];
  logic [15:0] exp_ok = 16'd0;
  logic [15:0] exp_err = 16'd0;
  logic rand_rdy = 1'b0;

  immenc dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_base(in_base), .in_kind(in_kind), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .cnt_clr(cnt_clr), .ok_cnt(ok_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference encoder written with integer range tests and mask/shift packing.
  function automatic logic [32:0] ref_enc(input logic [31:0] base, input logic [2:0] kind,
                                          input logic [31:0] imm);
    int si;
    logic err;
    logic [31:0] r;
    si = $signed(imm);
    case (kind)
      3'd0: err = 1'b0;
      3'd1: err = (imm > 32'd31);
      3'd2, 3'd3: err = (si < -2048) || (si > 2047);
      3'd4: err = (si < -4096) || (si > 4094) || imm[0];
      3'd5: err = (imm[11:0] != 12'd0);
      3'd6: err = (si < -1048576) || (si > 1048574) || imm[0];
      default: err = 1'b1;
    endcase
    r = base;
    if (!err) begin
      case (kind)
        3'd1: r = (base & 32'hFE0FFFFF) | ((imm & 32'h1F) << 20);
        3'd2: r = (base & 32'h000FFFFF) | (imm << 20);
        3'd3: r = (base & 32'h01FFF07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
        3'd4: r = (base & 32'h01FFF07F) | ({31'd0, imm[12]} << 31) | (((imm >> 5) & 32'h3F) << 25)
                  | (((imm >> 1) & 32'hF) << 8) | ({31'd0, imm[11]} << 7);
        3'd5: r = (base & 32'h00000FFF) | (imm & 32'hFFFFF000);
        3'd6: r = (base & 32'h00000FFF) | ({31'd0, imm[20]} << 31) | (((imm >> 1) & 32'h3FF) << 21)
                  | ({31'd0, imm[11]} << 20) | (imm & 32'h000FF000);
        default: r = base;
      endcase
    end
    return {err, r};
  endfunction

  // Drive one request, push its expectation on acceptance; returns #1 after the accepting edge.
  task automatic send(input logic [31:0] base, input logic [2:0] kind, input logic [31:0] imm,
                      input logic [32:0] exp);
    bit done = 0;
    in_valid = 1'b1;
    in_base  = base;
    in_kind  = kind;
    in_imm   = imm;
    for (int c = 0; c < 1000 && !done; c++) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        sb.push_back(exp);
        n_acc++;
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [31:0] base, input logic [2:0] kind, input logic [31:0] imm);
    send(base, kind, imm, ref_enc(base, kind, imm));
  endtask

  task automatic drain();
    int c = 0;
    while ((sb.size() != 0 || out_valid) && c < 2000) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("drain_timeout", 32'(c >= 2000), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag);
    check({tag, "_ok"}, 32'(ok_cnt), 32'(exp_ok));
    check({tag, "_err"}, 32'(err_cnt), 32'(exp_err));
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  logic [32:0] e;
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exp_ok  = 16'd0;
      exp_err = 16'd0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", out_instr, 32'hDEADBEEF);
        end else begin
          e = sb.pop_front();
          check("out_instr", out_instr, e[31:0]);
          check("out_err", 32'(out_err), 32'(e[32]));
        end
      end
      if (cnt_clr) begin
        exp_ok  = 16'd0;
        exp_err = 16'd0;
      end else if (out_valid && out_ready) begin
        if (out_err) begin
          if (exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
        end else if (exp_ok != 16'hFFFF) exp_ok = exp_ok + 16'd1;
      end
    end
  end

  logic [31:0] held;
  int bnd[13] = '{-2048, 2047, 2048, -2049, 4094, 4095, -4096, -4098,
                  1048574, -1048576, 1048576, 31, 32};

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_ok_cnt", 32'(ok_cnt), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // I-type with latency check
    send(32'h00000093, 3'd2, 32'hFFFFFFFF, {1'b0, 32'hFFF00093});
    @(negedge clk);
    check("lat_n1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_n2_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    check("ok_cnt_after_i", 32'(ok_cnt), 32'd1);

    // Directed encodings
    send(32'h00000063, 3'd4, 32'hFFFFFFFC, {1'b0, 32'hFE000EE3});
    send(32'h00000063, 3'd4, 32'd3,        {1'b1, 32'h00000063});
    drain();
    check("err_cnt_after_b", 32'(err_cnt), 32'd1);
    send(32'h00000063, 3'd4, 32'd4096,     {1'b1, 32'h00000063});
    send(32'h000000EF, 3'd6, 32'h00000800, {1'b0, 32'h001000EF});
    send(32'h00000037, 3'd5, 32'h12345000, {1'b0, 32'h12345037});
    send(32'h00000037, 3'd5, 32'h12345001, {1'b1, 32'h00000037});
    send(32'h40005013, 3'd1, 32'd31,       {1'b0, 32'h41F05013});
    send(32'h40005013, 3'd1, 32'd32,       {1'b1, 32'h40005013});
    send(32'h12345023, 3'd3, 32'hFFFFF800, {1'b0, 32'h80345023});
    send(32'hCAFEF00D, 3'd0, 32'h7FFFFFFF, {1'b0, 32'hCAFEF00D});
    send(32'hCAFEF00D, 3'd7, 32'd0,        {1'b1, 32'hCAFEF00D});
    drain();
    check_cnt("directed");

    // Backpressure: 4 offered, only 2 fit
    out_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        send_m(32'h00000013, 3'd2, 32'd1);
        send_m(32'h00000013, 3'd2, 32'd2);
        send_m(32'h00000013, 3'd2, 32'd3);
        send_m(32'h00000013, 3'd2, 32'd4);
      end
    join_none
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_accepted", 32'(n_acc), 32'd2);
    held = out_instr;
    repeat (5) @(negedge clk);
    check("bp_held", out_instr, held);
    check("bp_held_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #2 out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_stream_valid", 32'(out_valid), 32'd1);
    end
    wait fork;
    drain();
    check("bp_total", 32'(n_acc), 32'd4);

    // Boundary sweep with random backpressure
    rand_rdy = 1'b1;
    for (int k = 0; k < 8; k++)
      for (int b = 0; b < 13; b++)
        send_m($urandom(), 3'(k), 32'(bnd[b]));
    for (int i = 0; i < 40; i++)
      send_m($urandom(), 3'($urandom_range(0, 7)), $urandom());
    @(posedge clk);
    #2 rand_rdy = 1'b0;
    out_ready = 1'b1;
    drain();
    check_cnt("sweep");

    // Reset with 2 in flight
    out_ready = 1'b0;
    send_m(32'h00000013, 3'd2, 32'd5);
    send_m(32'h00000013, 3'd2, 32'd6);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_ok", 32'(ok_cnt), 32'd0);
    check("rst_mid_err", 32'(err_cnt), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_rel_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // cnt_clr coinciding with a handshake
    send_m(32'h00000013, 3'd2, 32'd7);
    @(posedge clk);
    #1;
    check("clr_hs_valid", 32'(out_valid), 32'd1);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    check("clr_hs_ok", 32'(ok_cnt), 32'd0);
    check("clr_hs_err", 32'(err_cnt), 32'd0);
    check("clr_hs_sb", 32'(sb.size()), 32'd0);

    // err_cnt saturation
    for (int i = 0; i < 65535; i++)
      send(32'h00000000, 3'd7, 32'd0, {1'b1, 32'h00000000});
    drain();
    check("sat_pre", 32'(err_cnt), 32'h0000FFFF);
    send(32'h00000000, 3'd7, 32'd0, {1'b1, 32'h00000000});
    drain();
    check("sat_hold", 32'(err_cnt), 32'h0000FFFF);
    check_cnt("sat");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
